// File: rtl/sdram_burst_arbiter_if.sv
// Bundles the requester-side and controller-side burst signals of the SDRAM burst arbiter.
// Latency: n/a (wiring only).
// Backpressure: n/a; the controller paces transfers with its data_req/data_valid strobes.
// Ports (slave = arbiter view, master = requesters + controller view):
//   p_*  per-port request buses packed [i] / [i*W +: W], plus routed return strobes
//   m_*  single burst-controller channel: registered requests, handshakes back in
interface sdram_burst_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 16
);
  // requester side
  logic [1:0]          p_rd_req;
  logic [1:0]          p_wr_req;
  logic [2*LEN_W-1:0]  p_rd_len;
  logic [2*LEN_W-1:0]  p_wr_len;
  logic [2*ADDR_W-1:0] p_rd_addr;
  logic [2*ADDR_W-1:0] p_wr_addr;
  logic [2*DATA_W-1:0] p_wr_data;
  logic [1:0]          p_wr_data_req;
  logic [1:0]          p_rd_data_valid;
  logic [DATA_W-1:0]   p_rd_data;
  logic [1:0]          p_wr_finish;
  logic [1:0]          p_rd_finish;

  // controller side
  logic                m_rd_req;
  logic                m_wr_req;
  logic [LEN_W-1:0]    m_rd_len;
  logic [LEN_W-1:0]    m_wr_len;
  logic [ADDR_W-1:0]   m_rd_addr;
  logic [ADDR_W-1:0]   m_wr_addr;
  logic [DATA_W-1:0]   m_wr_data;
  logic                m_wr_data_req;
  logic                m_rd_data_valid;
  logic [DATA_W-1:0]   m_rd_data;
  logic                m_wr_finish;
  logic                m_rd_finish;

  modport slave (
    input  p_rd_req, p_wr_req, p_rd_len, p_wr_len, p_rd_addr, p_wr_addr, p_wr_data,
    output p_wr_data_req, p_rd_data_valid, p_rd_data, p_wr_finish, p_rd_finish,
    output m_rd_req, m_wr_req, m_rd_len, m_wr_len, m_rd_addr, m_wr_addr, m_wr_data,
    input  m_wr_data_req, m_rd_data_valid, m_rd_data, m_wr_finish, m_rd_finish
  );

  modport master (
    output p_rd_req, p_wr_req, p_rd_len, p_wr_len, p_rd_addr, p_wr_addr, p_wr_data,
    input  p_wr_data_req, p_rd_data_valid, p_rd_data, p_wr_finish, p_rd_finish,
    input  m_rd_req, m_wr_req, m_rd_len, m_wr_len, m_rd_addr, m_wr_addr, m_wr_data,
    output m_wr_data_req, m_rd_data_valid, m_rd_data, m_wr_finish, m_rd_finish
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst controller between port 0 (loader) and port 1 (camera).
// Latency: request to m_*_req = 1 cycle; finish to m_*_req low = 1 cycle; min 2-cycle gap between bursts.
// Backpressure: requests are held by the requester until its finish; controller strobes pace the data.
// Ports: clk, rst_n (async active-low); port_en[1:0] arbitration enables; tmo_clr clears the
//   sticky timeout; grant[1:0] one-hot (00 idle); busy in BURST/DONE; timeout sticky watchdog flag;
//   bus = request/return/controller signals (see sdram_burst_arbiter_if).
module sdram_burst_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 10,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              port_en,
  input  logic                    tmo_clr,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic                    timeout,
  sdram_burst_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC);

  state_t              state_q, state_d;
  logic                prio_q;      // port that wins when both are eligible
  logic                gnt_port_q;  // port owning the current burst
  logic [1:0]          grant_q;
  logic                op_wr_q;     // latched operation of the current burst
  logic                m_rd_req_q, m_wr_req_q;
  logic [LEN_W-1:0]    m_rd_len_q, m_wr_len_q;
  logic [ADDR_W-1:0]   m_rd_addr_q, m_wr_addr_q;
  logic [15:0]         wdog_q;
  logic                timeout_q;

  logic [1:0]          elig;
  logic                win;
  logic                win_wr;
  logic                do_grant;
  logic                fin;
  logic                wdog_run;
  logic [LEN_W-1:0]    win_rd_len, win_wr_len;
  logic [ADDR_W-1:0]   win_rd_addr, win_wr_addr;

  // Arbitration and next-state
  always_comb begin
    elig     = port_en & (bus.p_rd_req | bus.p_wr_req);
    win      = 1'b0;
    case (elig)
      2'b10:   win = 1'b1;
      2'b11:   win = prio_q;
      default: win = 1'b0;
    endcase
    // a port asking for both directions gets its write served first
    win_wr      = win ? bus.p_wr_req[1] : bus.p_wr_req[0];
    win_rd_len  = win ? bus.p_rd_len[2*LEN_W-1:LEN_W]    : bus.p_rd_len[LEN_W-1:0];
    win_wr_len  = win ? bus.p_wr_len[2*LEN_W-1:LEN_W]    : bus.p_wr_len[LEN_W-1:0];
    win_rd_addr = win ? bus.p_rd_addr[2*ADDR_W-1:ADDR_W] : bus.p_rd_addr[ADDR_W-1:0];
    win_wr_addr = win ? bus.p_wr_addr[2*ADDR_W-1:ADDR_W] : bus.p_wr_addr[ADDR_W-1:0];

    // only the finish of the latched operation ends the burst
    fin      = op_wr_q ? bus.m_wr_finish : bus.m_rd_finish;

    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          do_grant = 1'b1;
          state_d  = ST_BURST;
        end
      end
      ST_BURST: begin
        if (fin) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Grant, latched burst parameters and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      gnt_port_q  <= 1'b0;
      grant_q     <= 2'b00;
      op_wr_q     <= 1'b0;
      m_rd_req_q  <= 1'b0;
      m_wr_req_q  <= 1'b0;
      m_rd_len_q  <= '0;
      m_wr_len_q  <= '0;
      m_rd_addr_q <= '0;
      m_wr_addr_q <= '0;
    end else begin
      if (do_grant) begin
        gnt_port_q  <= win;
        grant_q     <= win ? 2'b10 : 2'b01;
        op_wr_q     <= win_wr;
        m_wr_req_q  <= win_wr;
        m_rd_req_q  <= ~win_wr;
        m_rd_len_q  <= win_rd_len;
        m_wr_len_q  <= win_wr_len;
        m_rd_addr_q <= win_rd_addr;
        m_wr_addr_q <= win_wr_addr;
      end else if (state_q == ST_BURST && fin) begin
        grant_q    <= 2'b00;
        m_wr_req_q <= 1'b0;
        m_rd_req_q <= 1'b0;
      end
      if (state_q == ST_DONE) prio_q <= ~gnt_port_q;
    end
  end

  // Watchdog: counts BURST cycles without finish; flags once on reaching the limit
  // and saturates so a cleared flag is not re-raised by the same burst.
  assign wdog_run = (state_q == ST_BURST) && !fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (do_grant)
        wdog_q <= '0;
      else if (wdog_run && wdog_q != TMO_LIM)
        wdog_q <= wdog_q + 16'd1;

      // expiry beats a simultaneous clear
      if (wdog_run && wdog_q == TMO_LIM - 16'd1)
        timeout_q <= 1'b1;
      else if (tmo_clr)
        timeout_q <= 1'b0;
    end
  end

  // Controller-facing outputs
  assign bus.m_rd_req  = m_rd_req_q;
  assign bus.m_wr_req  = m_wr_req_q;
  assign bus.m_rd_len  = m_rd_len_q;
  assign bus.m_wr_len  = m_wr_len_q;
  assign bus.m_rd_addr = m_rd_addr_q;
  assign bus.m_wr_addr = m_wr_addr_q;
  assign bus.m_wr_data = grant_q[1] ? bus.p_wr_data[2*DATA_W-1:DATA_W] :
                         grant_q[0] ? bus.p_wr_data[DATA_W-1:0] : '0;

  // Return strobes reach only the granted port; finishes only for the latched operation
  assign bus.p_wr_data_req   = grant_q & {2{bus.m_wr_data_req}};
  assign bus.p_rd_data_valid = grant_q & {2{bus.m_rd_data_valid}};
  assign bus.p_rd_data       = bus.m_rd_data;
  assign bus.p_wr_finish     = op_wr_q  ? (grant_q & {2{bus.m_wr_finish}}) : 2'b00;
  assign bus.p_rd_finish     = !op_wr_q ? (grant_q & {2{bus.m_rd_finish}}) : 2'b00;

  assign grant   = grant_q;
  assign busy    = (state_q != ST_IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter: scoreboard of expected grants checked on each
// new controller request, plus directed checks of strobe routing, watchdog and reset.
// Clock 10 ns; inputs driven and outputs sampled on the falling edge.
module tb_sdram_burst_arbiter;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 10;
  localparam int DATA_W = 16;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] port_en;
  logic       tmo_clr;
  logic [1:0] grant;
  logic       busy;
  logic       timeout;

  sdram_burst_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus();

  sdram_burst_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TMO_CYC(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .port_en (port_en),
    .tmo_clr (tmo_clr),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        g;
    logic              wr;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void push(input logic [1:0] g, input logic wr,
                               input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.g = g; e.wr = wr; e.len = len; e.addr = addr;
    sb.push_back(e);
  endfunction

  // Scoreboard monitor: each new controller request must match the oldest expectation
  always @(negedge clk) begin
    if ((bus.m_wr_req && !prev_wr) || (bus.m_rd_req && !prev_rd)) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check("sb_grant", 64'(grant), 64'(mon_e.g));
        check("sb_op_wr", 64'(bus.m_wr_req), 64'(mon_e.wr));
        check("sb_len", 64'(mon_e.wr ? bus.m_wr_len : bus.m_rd_len), 64'(mon_e.len));
        check("sb_addr", 64'(mon_e.wr ? bus.m_wr_addr : bus.m_rd_addr), 64'(mon_e.addr));
      end
    end
    prev_wr = bus.m_wr_req;
    prev_rd = bus.m_rd_req;
  end

  task automatic set_req(input int p, input bit wr, input logic [LEN_W-1:0] len,
                         input logic [ADDR_W-1:0] addr);
    if (wr) begin
      bus.p_wr_req[p] = 1'b1;
      bus.p_wr_len[p*LEN_W +: LEN_W]    = len;
      bus.p_wr_addr[p*ADDR_W +: ADDR_W] = addr;
    end else begin
      bus.p_rd_req[p] = 1'b1;
      bus.p_rd_len[p*LEN_W +: LEN_W]    = len;
      bus.p_rd_addr[p*ADDR_W +: ADDR_W] = addr;
    end
  endtask

  // Bounded wait for the controller request of the given direction
  task automatic wait_req(input bit wr, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = wr ? bus.m_wr_req : bus.m_rd_req;
    end
    check(wr ? "wait_wr_req" : "wait_rd_req", 64'(seen), 64'd1);
  endtask

  // Controller model: stream beats, then finish; checks routing to port p only
  task automatic serve(input int p, input bit wr, input int beats, input bit drop);
    logic [DATA_W-1:0] rdat;
    for (int i = 0; i < beats; i++) begin
      rdat = 16'(i) ^ 16'hC3A0;
      bus.m_wr_data_req   = wr;
      bus.m_rd_data_valid = !wr;
      bus.m_rd_data       = rdat;
      #1;
      if (wr) begin
        check("wr_data_req_route", 64'(bus.p_wr_data_req), 64'd1 << p);
        check("m_wr_data_mux", 64'(bus.m_wr_data), (p == 1) ? 64'h5A5A : 64'hA5A5);
        check("rd_req_held_off", 64'(bus.m_rd_req), 64'd0);
      end else begin
        check("rd_valid_route", 64'(bus.p_rd_data_valid), 64'd1 << p);
        check("rd_data_bcast", 64'(bus.p_rd_data), 64'(rdat));
      end
      @(negedge clk);
    end
    bus.m_wr_data_req   = 1'b0;
    bus.m_rd_data_valid = 1'b0;
    if (wr) bus.m_wr_finish = 1'b1;
    else    bus.m_rd_finish = 1'b1;
    #1;
    check("finish_route", 64'(wr ? bus.p_wr_finish : bus.p_rd_finish), 64'd1 << p);
    check("finish_other_op", 64'(wr ? bus.p_rd_finish : bus.p_wr_finish), 64'd0);
    @(negedge clk);
    bus.m_wr_finish = 1'b0;
    bus.m_rd_finish = 1'b0;
    if (drop) begin
      if (wr) bus.p_wr_req[p] = 1'b0;
      else    bus.p_rd_req[p] = 1'b0;
    end
    check("done_req_low", 64'(bus.m_wr_req | bus.m_rd_req), 64'd0);
    check("done_grant", 64'(grant), 64'd0);
    check("done_busy", 64'(busy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    port_en = 2'b11;
    tmo_clr = 1'b0;
    bus.p_rd_req = '0;  bus.p_wr_req = '0;
    bus.p_rd_len = '0;  bus.p_wr_len = '0;
    bus.p_rd_addr = '0; bus.p_wr_addr = '0;
    bus.p_wr_data = {16'h5A5A, 16'hA5A5};
    bus.m_wr_data_req = 1'b0; bus.m_rd_data_valid = 1'b0;
    bus.m_rd_data = '0; bus.m_wr_finish = 1'b0; bus.m_rd_finish = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_m_req", 64'({bus.m_wr_req, bus.m_rd_req}), 64'd0);
    check("rst_m_len", 64'({bus.m_wr_len, bus.m_rd_len}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // port 0 write burst, 1-cycle request latency
    set_req(0, 1'b1, 10'd8, 24'h000100);
    push(2'b01, 1'b1, 10'd8, 24'h000100);
    wait_req(1'b1, 1);
    serve(0, 1'b1, 8, 1'b1);
    @(negedge clk);
    check("idle_after_done", 64'(busy), 64'd0);

    // port 1 read+write: write first, then read
    set_req(1, 1'b1, 10'd4, 24'h000A00);
    set_req(1, 1'b0, 10'd3, 24'h000B00);
    push(2'b10, 1'b1, 10'd4, 24'h000A00);
    push(2'b10, 1'b0, 10'd3, 24'h000B00);
    wait_req(1'b1, 2);
    serve(1, 1'b1, 4, 1'b1);
    wait_req(1'b0, 3);
    serve(1, 1'b0, 3, 1'b1);
    @(negedge clk);

    // both ports reading continuously: 01,10,01,10,01; port 0 uses len 0
    set_req(0, 1'b0, 10'd0, 24'h000200);
    set_req(1, 1'b0, 10'd5, 24'h000300);
    for (int k = 0; k < 5; k++)
      push((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, (k % 2 == 0) ? 10'd0 : 10'd5,
           (k % 2 == 0) ? 24'h000200 : 24'h000300);
    for (int k = 0; k < 5; k++) begin
      wait_req(1'b0, 3);
      serve(k % 2, 1'b0, (k % 2 == 0) ? 2 : 5, k >= 3);
    end
    @(negedge clk);

    // disabled port is never granted until enabled
    port_en = 2'b01;
    set_req(1, 1'b1, 10'd7, 24'h000700);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("disabled_no_grant", 64'({grant, busy}), 64'd0);
    end
    push(2'b10, 1'b1, 10'd7, 24'h000700);
    port_en = 2'b11;
    wait_req(1'b1, 3);
    serve(1, 1'b1, 3, 1'b1);
    @(negedge clk);

    // watchdog: finish withheld for TMO cycles
    check("tmo_pre", 64'(timeout), 64'd0);
    set_req(0, 1'b0, 10'd2, 24'h000400);
    push(2'b01, 1'b0, 10'd2, 24'h000400);
    wait_req(1'b0, 3);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k == TMO - 1) check("tmo_not_yet", 64'(timeout), 64'd0);
    end
    check("tmo_set", 64'(timeout), 64'd1);
    check("tmo_grant_held", 64'(grant), 64'd1);
    repeat (3) @(negedge clk);
    check("tmo_sticky", 64'(timeout), 64'd1);
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    check("tmo_cleared", 64'(timeout), 64'd0);
    serve(0, 1'b0, 2, 1'b1);
    @(negedge clk);

    // reset mid-burst, then priority back at port 0
    set_req(1, 1'b1, 10'd6, 24'h000600);
    push(2'b10, 1'b1, 10'd6, 24'h000600);
    wait_req(1'b1, 3);
    bus.m_wr_data_req = 1'b1;
    @(negedge clk);
    bus.m_wr_data_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_m_req", 64'({bus.m_wr_req, bus.m_rd_req}), 64'd0);
    check("arst_grant", 64'(grant), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    bus.p_wr_req = '0;
    @(negedge clk);
    set_req(0, 1'b0, 10'd4, 24'h000800);
    set_req(1, 1'b0, 10'd4, 24'h000900);
    push(2'b01, 1'b0, 10'd4, 24'h000800);
    push(2'b10, 1'b0, 10'd4, 24'h000900);
    rst_n = 1'b1;
    wait_req(1'b0, 2);
    serve(0, 1'b0, 2, 1'b1);
    wait_req(1'b0, 3);
    serve(1, 1'b0, 2, 1'b1);
    repeat (2) @(negedge clk);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
